// File: rtl/matrix_keypad_scanner.sv
// Matrix keypad scanner: idle wake-up, column sweep, per-sweep debounce,
// valid/ready code output with sticky overrun flag.
// Optional auto-repeat while a key is held: define KEYPAD_AUTO_REPEAT_EN.
module matrix_keypad_scanner #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned DWELL         = 4,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_SWEEPS = 32,
  localparam int unsigned CODE_W       = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              key_down,
  output logic              multi,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned NW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StScan, StHeld} state_e;
  typedef enum logic [1:0] {ResNone, ResOne, ResMulti} res_e;

  state_e            state_q;
  logic [COLS-1:0]   col_q;
  logic [CW-1:0]     col_idx_q;
  logic [DW-1:0]     dwell_q;
  logic [1:0]        hits_q;       // row bits seen so far this sweep, saturating at 2
  logic [CODE_W-1:0] key_q;
  logic              res_valid_q;  // one-cycle pulse: a sweep result is ready to process
  res_e              res_kind_q, prev_kind_q;
  logic [CODE_W-1:0] res_key_q, prev_key_q;
  logic [NW-1:0]     cnt_q, none_q;
  logic [CODE_W-1:0] code_q;
  logic              code_valid_q, key_down_q, multi_q, overrun_q;

  logic [1:0]        row_hits, hits_next;
  logic [2:0]        tot;
  logic [CODE_W-1:0] row_key;
  logic              sample, last_col, one_same, enter_held, exit_idle, rep_hit, emit;
  logic [NW-1:0]     cnt_next, none_next;

  // Accumulate row hits for the column being sampled
  always_comb begin
    row_hits = 2'd0;
    row_key  = key_q;
    for (int r = 0; r < ROWS; r++) begin
      if (row[r]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_key = CODE_W'(r * COLS) + CODE_W'(col_idx_q);
      end
    end
    tot       = {1'b0, hits_q} + {1'b0, row_hits};
    hits_next = (tot >= 3'd2) ? 2'd2 : tot[1:0];
  end

  // Debounce bookkeeping for the sweep result being processed this cycle
  always_comb begin
    sample     = (dwell_q == DW'(DWELL - 1));
    last_col   = (col_idx_q == CW'(COLS - 1));
    one_same   = (res_kind_q == ResOne) && (prev_kind_q == ResOne) && (res_key_q == prev_key_q);
    cnt_next   = (res_kind_q == ResOne) ? (one_same ? cnt_q + 1'b1 : NW'(1)) : '0;
    none_next  = (res_kind_q == ResNone) ? none_q + 1'b1 : '0;
    enter_held = res_valid_q && (state_q == StScan) && (cnt_next == NW'(DEBOUNCE));
    exit_idle  = res_valid_q && (state_q != StIdle) && (none_next == NW'(DEBOUNCE));
    emit       = enter_held || rep_hit;
  end

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_SWEEPS + 1);
  logic [RW-1:0]     rep_q, rep_next;
  logic [CODE_W-1:0] held_key_q;

  // Count consecutive sweeps that still see the held key
  always_comb begin
    rep_next = ((res_kind_q == ResOne) && (res_key_q == held_key_q)) ? rep_q + 1'b1 : '0;
    rep_hit  = res_valid_q && (state_q == StHeld) && (rep_next == RW'(REPEAT_SWEEPS));
  end

  // Repeat counter and the key it is tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q      <= '0;
      held_key_q <= '0;
    end else if (enter_held) begin
      rep_q      <= '0;
      held_key_q <= res_key_q;
    end else if (res_valid_q && (state_q == StHeld)) begin
      rep_q <= rep_hit ? '0 : rep_next;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  // Main FSM: sweep timing, debounce, output handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '1;
      col_idx_q    <= '0;
      dwell_q      <= '0;
      hits_q       <= '0;
      key_q        <= '0;
      res_valid_q  <= 1'b0;
      res_kind_q   <= ResNone;
      res_key_q    <= '0;
      prev_kind_q  <= ResNone;
      prev_key_q   <= '0;
      cnt_q        <= '0;
      none_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      key_down_q   <= 1'b0;
      multi_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      multi_q     <= 1'b0;
      res_valid_q <= 1'b0;

      // A pending untransferred code wins over a new one
      if (emit) begin
        if (code_valid_q && !code_ready) begin
          overrun_q <= 1'b1;
        end else begin
          code_q       <= res_key_q;
          code_valid_q <= 1'b1;
        end
      end else if (code_valid_q && code_ready) begin
        code_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          col_q <= '1;
          if (|row) begin
            state_q     <= StScan;
            col_q       <= COLS'(1);
            col_idx_q   <= '0;
            dwell_q     <= '0;
            hits_q      <= '0;
            cnt_q       <= '0;
            none_q      <= '0;
            prev_kind_q <= ResNone;
          end
        end
        default: begin
          if (sample) begin
            dwell_q <= '0;
            if (last_col) begin
              col_idx_q   <= '0;
              col_q       <= COLS'(1);
              hits_q      <= '0;
              res_valid_q <= 1'b1;
              res_key_q   <= row_key;
              res_kind_q  <= (hits_next == 2'd0) ? ResNone :
                             (hits_next == 2'd1) ? ResOne : ResMulti;
              multi_q     <= (hits_next == 2'd2);
            end else begin
              col_idx_q <= col_idx_q + 1'b1;
              col_q     <= COLS'(1) << (col_idx_q + 1'b1);
              hits_q    <= hits_next;
              key_q     <= row_key;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end

          if (res_valid_q) begin
            prev_kind_q <= res_kind_q;
            prev_key_q  <= res_key_q;
            none_q      <= none_next;
            if (state_q == StScan) cnt_q <= cnt_next;
            if (enter_held) begin
              state_q    <= StHeld;
              key_down_q <= 1'b1;
            end else if (exit_idle) begin
              state_q    <= StIdle;
              col_q      <= '1;
              key_down_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign col        = col_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign key_down   = key_down_q;
  assign multi      = multi_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Scoreboard bench for matrix_keypad_scanner at default parameters.
module tb_matrix_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b1;
  logic        key_down, multi, overrun;

  logic [15:0] keys = '0;   // pressed keys, index r*4+c
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {int code; int cyc;} exp_t;  // cyc < 0: timing not checked
  exp_t sb[$];
  exp_t e;
  logic hold_q = 1'b0;
  logic [3:0] held_code = '0;

  matrix_keypad_scanner dut (
    .clock      (clock),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .key_down   (key_down),
    .multi      (multi),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive keypad: a pressed key connects its column drive to its row
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) row[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    if (c > cyc) step(c - cyc);
  endtask

  // Monitor: stability while stalled, and scoreboard pop on each transfer
  always @(negedge clock) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        checks++;
        if (!code_valid || code !== held_code) begin
          errors++;
          $display("FAIL stall_stable at cycle %0d: got valid=%0b code=%0d, expected valid=1 code=%0d",
                   cyc, code_valid, code, held_code);
        end
      end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_code at cycle %0d: got code %0d, expected no transfer", cyc, code);
        end else begin
          e = sb.pop_front();
          if (code !== 4'(e.code) || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL transfer at cycle %0d: got code %0d, expected code %0d at cycle %0d",
                     cyc, code, e.code, e.cyc);
          end
        end
      end
      hold_q    <= code_valid && !code_ready;
      held_code <= code;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, pulses;
    logic saw_hold;

    // Reset values
    step(3);
    check("rst_col", 32'(col), 32'hF);
    check("rst_code", 32'(code), 0);
    check("rst_valid", 32'(code_valid), 0);
    check("rst_key_down", 32'(key_down), 0);
    check("rst_multi", 32'(multi), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    step(2);

    // Clean press of key 9 (row 2, col 1), then release
    p = cyc;
    keys[9] = 1'b1;
    sb.push_back('{9, p + 50});
    wait_until(p + 49);
    check("k9_early_valid", 32'(code_valid), 0);
    wait_until(p + 50);
    check("k9_valid", 32'(code_valid), 1);
    check("k9_code", 32'(code), 9);
    check("k9_key_down", 32'(key_down), 1);
    keys = '0;
    wait_until(p + 51);
    check("k9_valid_one_cycle", 32'(code_valid), 0);
    wait_until(p + 97);
    check("k9_still_down", 32'(key_down), 1);
    wait_until(p + 98);
    check("k9_released", 32'(key_down), 0);
    wait_until(p + 99);
    check("k9_idle_col", 32'(col), 32'hF);
    step(5);

    // Two keys together: multi each sweep, no code
    p = cyc;
    keys[4] = 1'b1;
    keys[15] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (multi) pulses++;
      if (cyc == p + 17) check("multi_first", 32'(multi), 1);
      if (cyc == p + 18) check("multi_one_cycle", 32'(multi), 0);
    end
    check("multi_pulses", 32'(pulses), 6);
    check("multi_no_key_down", 32'(key_down), 0);
    keys = '0;
    step(80);
    check("multi_idle_col", 32'(col), 32'hF);

    // Bouncing key 3 (row 0, col 3): never accepted
    saw_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 5 == 0) keys[3] = ~keys[3];
      step(1);
      if (key_down) saw_hold = 1'b1;
    end
    check("bounce_no_hold", 32'(saw_hold), 0);
    keys = '0;
    step(80);
    check("bounce_idle_col", 32'(col), 32'hF);

    // Stalled consumer: key 15 pending, then key 9 dropped with overrun
    code_ready = 1'b0;
    p = cyc;
    keys[15] = 1'b1;
    sb.push_back('{15, -1});
    wait_until(p + 50);
    check("k15_valid", 32'(code_valid), 1);
    check("k15_code", 32'(code), 15);
    check("k15_no_overrun", 32'(overrun), 0);
    wait_until(p + 100);
    keys = '0;
    wait_until(p + 150);
    check("k15_released", 32'(key_down), 0);
    wait_until(p + 160);
    keys[9] = 1'b1;
    wait_until(p + 209);
    check("ovr_not_yet", 32'(overrun), 0);
    wait_until(p + 210);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_code_kept", 32'(code), 15);
    wait_until(p + 250);
    code_ready = 1'b1;
    step(1);
    check("k15_transferred", 32'(code_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    keys = '0;
    step(80);

`ifdef KEYPAD_AUTO_REPEAT_EN
    // Auto-repeat of key 5, then overrun once the consumer stalls
    p = cyc;
    keys[5] = 1'b1;
    sb.push_back('{5, p + 50});
    sb.push_back('{5, p + 562});
    sb.push_back('{5, p + 1074});
    sb.push_back('{5, -1});
    wait_until(p + 1080);
    code_ready = 1'b0;
    wait_until(p + 1586);
    check("rep_pending", 32'(code_valid), 1);
    wait_until(p + 2100);
    check("rep_overrun", 32'(overrun), 1);
    code_ready = 1'b1;
    keys = '0;
    step(80);
`endif

    // Reset mid-press discards state; fresh latency afterwards
    p = cyc;
    keys[9] = 1'b1;
    wait_until(p + 29);
    reset = 1'b1;
    step(1);
    check("mid_rst_col", 32'(col), 32'hF);
    check("mid_rst_code", 32'(code), 0);
    check("mid_rst_valid", 32'(code_valid), 0);
    check("mid_rst_key_down", 32'(key_down), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    sb.push_back('{9, p + 80});
    wait_until(p + 79);
    check("post_rst_early", 32'(code_valid), 0);
    wait_until(p + 80);
    check("post_rst_valid", 32'(code_valid), 1);
    check("post_rst_code", 32'(code), 9);
    keys = '0;
    step(80);

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
